mux_nto1_arb: RTL and testbench
===============================

Name: mux_nto1_arb

Overview:
- Parametrised N-to-1 data multiplexer, successor to the team's 2:1 combinational mux.
- Selects among N valid/ready input channels, using either fixed-priority or round-robin arbitration.
- Registers the winning word into a single-entry output stage with its own valid/ready handshake.
- Sits between multiple producer blocks and one shared consumer; sustains one transfer per cycle.

Parameters:
WIDTH, 8, data width of each channel in bits (>=1)
N, 4, number of input channels (>=1)
MODE, 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round robin; any other value is illegal
SEL_W, derived = max(1, clog2(N)), width of the channel index; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low; release is synchronous to clk externally
in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready; at most one bit high per cycle
out_data  output  WIDTH  registered selected data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts out_data this cycle
out_sel  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Reset (rst_n=0, effective immediately):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready is all-zero while rst_n=0.
  - Any word held in the output register is discarded.
- load = !out_valid | out_ready (output register empty, or being drained this cycle).
- Grant (combinational):
  - MODE=0: lowest index i with in_valid[i]=1.
  - MODE=1: first index with in_valid set, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... modulo N.
- in_ready[i] = load & any(in_valid) & (i==grant).
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must never depend on in_ready.
- Accept (load & any(in_valid)) at the clock edge:
  - out_data <= channel[grant]; out_sel <= grant; out_valid <= 1.
  - MODE=1 only: rr_ptr <= (grant==N-1) ? 0 : grant+1.
- load with no valid input: out_valid <= 0; out_data and out_sel hold their last values; rr_ptr unchanged.
- Stall (out_valid & !out_ready): out_data, out_sel and rr_ptr hold; all in_ready=0.
- Simultaneous drain and accept in one cycle: new word replaces the old one with no bubble.
- Throughput and latency:
  - Sustained throughput is 1 word/cycle.
  - Latency is 1 cycle from input accept to out_valid.
- Fairness:
  - MODE=1: a continuously asserted channel waits at most N-1 grants.
  - MODE=0: no fairness guarantee.
- Input protocol:
  - Inputs must hold in_valid and in_data stable until accepted.
  - The block does not check this; a dropped request simply loses arbitration.
- N=1: grant is always 0, rr_ptr stays 0, out_sel=0; the block degenerates to a registered pipeline stage.
- No output changes except on the rising clk edge or on asynchronous reset assertion.

Test Plan:
- Reset, then apply in_valid=4'b0000, out_ready=1 -> out_valid=0, in_ready=4'b0000, out_data=0, out_sel=0 for 5 cycles.
- MODE=1, N=4, all channels valid continuously with data 8'hA0..8'hA3, out_ready=1 -> out_sel sequence 0,1,2,3,0,1, out_data A0,A1,A2,A3,A0,A1, out_valid high every cycle after the first.
- MODE=0, same stimulus -> out_sel stays 0 and out_data stays A0 every cycle; in_ready=4'b0001 throughout.
- MODE=1, out_ready=0 for 3 cycles after first accept of A0 -> out_data=A0 and out_sel=0 held; in_ready=0; on out_ready=1, A0 drains and A1 loads in the same cycle (no bubble).
- MODE=1, only channel 2 valid (data 8'h5C) -> single accept: out_sel=2, out_data=5C; next grant search starts at 3, so channels 3 and 2 valid together -> 3 wins.
- Assert rst_n=0 mid-stream while out_valid=1 -> out_valid drops asynchronously before the next edge; after release, arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_nto1_arb_if.sv
// mux_nto1_arb_if: bundle of the N-to-1 arbitrating mux's handshake/bus signals.
//
// Handshake rule, valid/ready on every channel: a word moves across a channel
// exactly on a rising clk edge where that channel's valid and ready are both
// high. A producer holds valid and data stable until that edge; ready may
// depend combinationally on valid, never the reverse.
//
// Signals:
//   in_data   N*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  N        per-channel valid
//   in_ready  N        per-channel ready, at most one bit high
//   out_data  WIDTH    registered selected word
//   out_valid 1        output register holds a word
//   out_ready 1        consumer takes out_data this cycle
//   out_sel   SEL_W    index of the channel that supplied out_data
// Modports: master = producers/consumer side, slave = the mux itself.
interface mux_nto1_arb_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_nto1_arb.sv
// mux_nto1_arb: N-to-1 data multiplexer with fixed-priority (MODE=0) or
// round-robin (MODE=1) arbitration feeding a single-entry registered output
// stage. Sustains one transfer per cycle; one cycle latency to out_valid.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_nto1_arb_if.slave (channel inputs, registered output)
module mux_nto1_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_nto1_arb_if.slave    bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  if (MODE != 0 && MODE != 1) begin : g_mode_check
    $error("mux_nto1_arb: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] chan [N];
  logic             any_valid;
  logic             load;
  logic [SEL_W-1:0] grant;
  logic [N-1:0]     ready_onehot;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign chan[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign any_valid = |bus.in_valid;
  // Register empty or being drained this cycle: a new word may enter.
  assign load      = !out_valid_q || bus.out_ready;

  // Walk the search order from last to first so the earliest valid candidate
  // is the final (winning) assignment. In MODE=0 rr_ptr_q stays 0, but the
  // order is pinned to 0..N-1 explicitly.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (MODE == 1) idx = int'(rr_ptr_q) + k;
      else           idx = k;
      if (idx >= N) idx = idx - N;
      if (bus.in_valid[SEL_W'(idx)]) grant = SEL_W'(idx);
    end
  end

  // rst_n gating keeps in_ready low for the whole reset, even though an
  // empty output register would otherwise advertise load.
  always_comb begin
    ready_onehot = '0;
    if (rst_n && load && any_valid) ready_onehot[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = chan[grant];
        out_sel_d   = grant;
        if (MODE == 1) begin
          rr_ptr_d = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
        end
      end else begin
        // Drained with nothing to replace it; data/sel keep last values.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = ready_onehot;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_nto1_arb.sv
// Bench for mux_nto1_arb: a round-robin instance and a fixed-priority
// instance share one stimulus stream. Expected words for the round-robin
// instance are pushed when accepted and popped after the clock edge.
module tb_mux_nto1_arb;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int EW    = 2 + WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       vld;
  logic [N*WIDTH-1:0] dat;
  logic               ordy;

  mux_nto1_arb_if #(.WIDTH(WIDTH), .N(N)) bus_rr ();
  mux_nto1_arb_if #(.WIDTH(WIDTH), .N(N)) bus_fp ();

  assign bus_rr.in_valid  = vld;
  assign bus_rr.in_data   = dat;
  assign bus_rr.out_ready = ordy;
  assign bus_fp.in_valid  = vld;
  assign bus_fp.in_data   = dat;
  assign bus_fp.out_ready = ordy;

  mux_nto1_arb #(.WIDTH(WIDTH), .N(N), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr)
  );
  mux_nto1_arb #(.WIDTH(WIDTH), .N(N), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp)
  );

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state for the round-robin instance.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_sel;
  logic [1:0]       m_ptr;

  int exp_sel [6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(m_ptr) + k) % N;
      if (vld[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;
    m_ptr   = '0;
    exp_q.delete();
  endtask

  // Called at posedge+1 with inputs already set; ends at the next posedge+1.
  task automatic step(input string tag);
    logic          ld, acc;
    logic [N-1:0]  rdy_exp;
    logic [EW-1:0] item;
    int            g;
    #3;
    ld      = !m_valid || ordy;
    g       = model_grant();
    acc     = ld && (|vld);
    rdy_exp = acc ? (N'(1) << g) : '0;
    chk({tag, "/in_ready"}, 32'(bus_rr.in_ready), 32'(rdy_exp));
    if (acc) exp_q.push_back({2'(g), dat[g*WIDTH +: WIDTH]});
    @(posedge clk);
    #1;
    if (acc) begin
      item    = exp_q.pop_front();
      m_valid = 1'b1;
      m_sel   = item[EW-1 -: 2];
      m_data  = item[WIDTH-1:0];
      m_ptr   = (g == N - 1) ? 2'd0 : 2'(g + 1);
    end else if (ld) begin
      m_valid = 1'b0;
    end
    chk({tag, "/out_valid"}, 32'(bus_rr.out_valid), 32'(m_valid));
    chk({tag, "/out_data"},  32'(bus_rr.out_data),  32'(m_data));
    chk({tag, "/out_sel"},   32'(bus_rr.out_sel),   32'(m_sel));
  endtask

  task automatic do_reset();
    vld   = '1;
    rst_n = 1'b0;
    #1;
    chk("reset/in_ready_rr", 32'(bus_rr.in_ready), 32'h0);
    chk("reset/in_ready_fp", 32'(bus_fp.in_ready), 32'h0);
    chk("reset/out_valid",   32'(bus_rr.out_valid), 32'h0);
    vld = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vld  = '0;
    dat  = '0;
    ordy = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Idle after reset: nothing valid, nothing moves.
    do_reset();
    for (int i = 0; i < 5; i++) step("idle");
    chk("idle/out_data_zero", 32'(bus_rr.out_data), 32'h0);

    // All channels valid, consumer always ready: rr rotates, fp sticks at 0.
    do_reset();
    dat  = 32'hA3A2A1A0;
    vld  = 4'b1111;
    ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr_all");
      chk("rr_all/sel_seq",  32'(bus_rr.out_sel),  32'(exp_sel[i]));
      chk("rr_all/data_seq", 32'(bus_rr.out_data), 32'(8'hA0 + exp_sel[i]));
      chk("fp_all/out_sel",  32'(bus_fp.out_sel),  32'h0);
      chk("fp_all/out_data", 32'(bus_fp.out_data), 32'hA0);
      chk("fp_all/out_valid", 32'(bus_fp.out_valid), 32'h1);
      chk("fp_all/in_ready", 32'(bus_fp.in_ready), 32'b0001);
    end

    // Stall after first accept, then drain and reload with no bubble.
    do_reset();
    dat  = 32'hA3A2A1A0;
    vld  = 4'b1111;
    ordy = 1'b0;
    step("stall_first");
    for (int i = 0; i < 3; i++) begin
      step("stall_hold");
      chk("stall_hold/data", 32'(bus_rr.out_data), 32'hA0);
    end
    ordy = 1'b1;
    step("stall_release");
    chk("stall_release/data", 32'(bus_rr.out_data), 32'hA1);
    chk("stall_release/sel",  32'(bus_rr.out_sel),  32'h1);

    // Single requester on channel 2, then pointer resumes at 3.
    do_reset();
    dat = 32'h005C0000;
    vld = 4'b0100;
    step("ch2_only");
    chk("ch2_only/sel",  32'(bus_rr.out_sel),  32'h2);
    chk("ch2_only/data", 32'(bus_rr.out_data), 32'h5C);
    dat = 32'h775C0000;
    vld = 4'b1100;
    step("ch3_wins");
    chk("ch3_wins/sel", 32'(bus_rr.out_sel), 32'h3);
    step("ch2_after3");
    chk("ch2_after3/sel", 32'(bus_rr.out_sel), 32'h2);

    // Random traffic against the reference.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      vld  = N'($urandom_range(0, 15));
      ordy = 1'($urandom_range(0, 1));
      dat  = $urandom;
      step("rand");
    end

    // Asynchronous reset mid-stream.
    do_reset();
    dat  = 32'hA3A2A1A0;
    vld  = 4'b1111;
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) step("pre_async");
    chk("async/valid_before", 32'(bus_rr.out_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async/valid_dropped", 32'(bus_rr.out_valid), 32'h0);
    chk("async/data_cleared",  32'(bus_rr.out_data),  32'h0);
    chk("async/in_ready_zero", 32'(bus_rr.in_ready),  32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step("post_async");
    chk("post_async/sel", 32'(bus_rr.out_sel), 32'h0);
    step("post_async2");
    chk("post_async2/sel", 32'(bus_rr.out_sel), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
